// File: rtl/spi_serf_if.sv
// Parallel-side handshake between the SPI serf and its local consumer.
interface spi_serf_if;
    localparam int unsigned WORD_W = 16;

    logic [WORD_W-1:0] tx_data;
    logic [WORD_W-1:0] rx_data;
    logic              rdy;
    logic              clr_rdy;
    logic              frame_err;

    modport master (
        output tx_data,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frame_err
    );

    modport slave (
        input  tx_data,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frame_err
    );
endinterface

// File: rtl/spi_serf.sv
// SPI responder for the 16-bit monarch link: captures one word per frame on
// SCLK rises and shifts a preloaded response out on MISO in the same frame.
module spi_serf #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    spi_serf_if.slave  host
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(31);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_hist, sclk_hist;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   sclk_rise, ss_fall, ss_rise;

    logic [WORD_W-1:0] shift, shift_nxt, shift_upd;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt, cnt_upd;
    logic [WORD_W-1:0] rx_nxt;
    logic              rdy_nxt, ferr_nxt;
    logic              miso_en;

    // Metastability chains plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '1;
            ss_hist   <= 1'b1;
            sclk_hist <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_hist   <= ss_s;
            sclk_hist <= sclk_s;
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign ss_fall   = ~ss_s & ss_hist;
    assign ss_rise   = ss_s & ~ss_hist;

    // State register and frame datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            shift          <= '0;
            bit_cnt        <= '0;
            host.rx_data   <= '0;
            host.rdy       <= 1'b0;
            host.frame_err <= 1'b0;
        end else begin
            state          <= state_nxt;
            shift          <= shift_nxt;
            bit_cnt        <= cnt_nxt;
            host.rx_data   <= rx_nxt;
            host.rdy       <= rdy_nxt;
            host.frame_err <= ferr_nxt;
        end
    end

    // Next state; a same-clk SCLK rise is folded in before the end-of-frame check
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = bit_cnt;
        rx_nxt    = host.rx_data;
        rdy_nxt   = host.rdy;
        ferr_nxt  = host.frame_err;
        shift_upd = shift;
        cnt_upd   = bit_cnt;

        if (host.clr_rdy) rdy_nxt = 1'b0;

        if (sclk_rise) begin
            shift_upd = {shift[WORD_W-2:0], mosi_s};
            cnt_upd   = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    shift_nxt = host.tx_data;
                    cnt_nxt   = '0;
                    rdy_nxt   = 1'b0;
                    ferr_nxt  = 1'b0;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                shift_nxt = shift_upd;
                cnt_nxt   = cnt_upd;
                if (ss_rise) begin
                    state_nxt = IDLE;
                    if (cnt_upd == CNT_FULL) begin
                        rx_nxt  = shift_upd;
                        rdy_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    assign miso_en = (state == ACTIVE);
    assign MISO    = miso_en ? shift[WORD_W-1] : 1'bz;

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a monarch task drives frames at clk/16 while a
// frame-level model predicts rx_data/rdy/frame_err and MISO enable every clk.
module tb_spi_serf;
    logic clk = 1'b0;
    logic rst_n;
    logic ss_n;
    logic sclk;
    logic mosi;
    wire  miso;

    spi_serf_if bus ();

    spi_serf #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (ss_n),
        .SCLK  (sclk),
        .MOSI  (mosi),
        .MISO  (miso),
        .host  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] exp_rx;
    logic        exp_rdy;
    logic        exp_ferr;
    logic        exp_active;
    bit          chk_en = 1'b0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-clk comparison of DUT outputs against the frame-level model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check16("rx_data", bus.rx_data, exp_rx);
            check16("rdy", 16'(bus.rdy), 16'(exp_rdy));
            check16("frame_err", 16'(bus.frame_err), 16'(exp_ferr));
            check16("miso_driven", 16'(dut.miso_en), 16'(exp_active));
        end
    end

    // One monarch frame; the model changes 3 clks after each SS_n pin edge
    task automatic frame(input logic [15:0] tx, input logic [15:0] wr, input int nbits,
                         input bit do_end, output logic [15:0] rd);
        rd = '0;
        @(negedge clk);
        bus.tx_data = tx;
        ss_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_active = 1'b1;
        exp_rdy    = 1'b0;
        exp_ferr   = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = wr[15-i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            @(negedge clk);
            rd[15-i] = miso;
            repeat (7) @(negedge clk);
        end
        if (do_end) begin
            repeat (8) @(negedge clk);
            ss_n = 1'b1;
            repeat (2) @(negedge clk);
            exp_active = 1'b0;
            if (nbits == 16) begin
                exp_rx  = wr;
                exp_rdy = 1'b1;
            end else begin
                exp_ferr = 1'b1;
            end
        end
    endtask

    logic [15:0] rd;

    initial begin
        rst_n       = 1'b0;
        ss_n        = 1'b1;
        sclk        = 1'b1;
        mosi        = 1'b0;
        bus.tx_data = '0;
        bus.clr_rdy = 1'b0;
        exp_rx      = '0;
        exp_rdy     = 1'b0;
        exp_ferr    = 1'b0;
        exp_active  = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check16("reset_rx", bus.rx_data, 16'h0000);
        check16("reset_rdy", 16'(bus.rdy), 16'h0);
        check16("reset_ferr", 16'(bus.frame_err), 16'h0);
        check16("reset_miso_driven", 16'(dut.miso_en), 16'h0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Basic full frame
        frame(16'hA5C3, 16'h1234, 16, 1'b1, rd);
        @(negedge clk);
        check16("t1_miso_word", rd, 16'hA5C3);
        check16("t1_rx", bus.rx_data, 16'h1234);
        check16("t1_rdy", 16'(bus.rdy), 16'h1);
        check16("t1_ferr", 16'(bus.frame_err), 16'h0);
        repeat (4) @(negedge clk);

        // Two frames with an acknowledge in between
        frame(16'h8000, 16'hFFFF, 16, 1'b1, rd);
        @(negedge clk);
        check16("t2a_miso_word", rd, 16'h8000);
        check16("t2a_rx", bus.rx_data, 16'hFFFF);
        bus.clr_rdy = 1'b1;
        exp_rdy     = 1'b0;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        check16("t2_rdy_cleared", 16'(bus.rdy), 16'h0);
        repeat (3) @(negedge clk);
        frame(16'h7FFF, 16'h0001, 16, 1'b1, rd);
        @(negedge clk);
        check16("t2b_miso_word", rd, 16'h7FFF);
        check16("t2b_rx", bus.rx_data, 16'h0001);
        check16("t2b_rdy", 16'(bus.rdy), 16'h1);
        repeat (4) @(negedge clk);

        // Short frame, then recovery
        frame(16'h1111, 16'hFFFF, 9, 1'b1, rd);
        @(negedge clk);
        check16("t3_ferr", 16'(bus.frame_err), 16'h1);
        check16("t3_rdy", 16'(bus.rdy), 16'h0);
        check16("t3_rx_kept", bus.rx_data, 16'h0001);
        repeat (4) @(negedge clk);
        frame(16'h2468, 16'h1357, 16, 1'b1, rd);
        @(negedge clk);
        check16("t3b_miso_word", rd, 16'h2468);
        check16("t3b_rx", bus.rx_data, 16'h1357);
        check16("t3b_ferr", 16'(bus.frame_err), 16'h0);
        repeat (4) @(negedge clk);

        // clr_rdy held across a successful frame end: set wins for one clk
        bus.clr_rdy = 1'b1;
        exp_rdy     = 1'b0;
        frame(16'h0F0F, 16'hBEEF, 16, 1'b1, rd);
        @(negedge clk);
        check16("t4_rdy_set_wins", 16'(bus.rdy), 16'h1);
        check16("t4_rx", bus.rx_data, 16'hBEEF);
        exp_rdy = 1'b0;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        check16("t4_rdy_cleared", 16'(bus.rdy), 16'h0);
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame
        frame(16'h0000, 16'h5555, 8, 1'b0, rd);
        @(negedge clk);
        rst_n      = 1'b0;
        exp_rx     = '0;
        exp_rdy    = 1'b0;
        exp_ferr   = 1'b0;
        exp_active = 1'b0;
        #1;
        check16("t5_rx_reset", bus.rx_data, 16'h0000);
        check16("t5_rdy_reset", 16'(bus.rdy), 16'h0);
        check16("t5_miso_released", 16'(dut.miso_en), 16'h0);
        @(negedge clk);
        ss_n = 1'b1;
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // SCLK activity with the serf deselected
        for (int k = 0; k < 4; k++) begin
            sclk = 1'b0;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
        end
        check16("t6_bit_cnt", 16'(dut.bit_cnt), 16'h0000);
        check16("t6_rx", bus.rx_data, 16'h0000);

        // Full frame after the reset
        frame(16'h3C3C, 16'hC0DE, 16, 1'b1, rd);
        @(negedge clk);
        check16("t7_miso_word", rd, 16'h3C3C);
        check16("t7_rx", bus.rx_data, 16'hC0DE);
        check16("t7_rdy", 16'(bus.rdy), 16'h1);
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: run did not complete, got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_serf.md
Name: spi_serf

Overview:
- SPI responder (serf) for the 16-bit monarch link used by the flight-control SPI bus.
- Watches SS_n/SCLK/MOSI from a monarch running SCLK at clk/16, where SCLK idles high, MOSI changes just after each SCLK rise and MISO is sampled just after each rise.
- Captures one 16-bit word per frame, presents it with a ready flag, and shifts a preloaded 16-bit response out on MISO during the same frame.
- Used as the sensor-side model and on-board responder in the quadcopter system.

Parameters:
- SYNC_STAGES, 2, metastability flops on SS_n, SCLK and MOSI before use. The edge detector adds one further stage on SS_n and SCLK.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  active-low serf select from the monarch (asynchronous)
- SCLK  input  1  serial clock from the monarch (asynchronous, idles high)
- MOSI  input  1  serial data from the monarch, MSB first
- MISO  output  1  serial data to the monarch, MSB first; high-Z while SS_n (synchronized) is high
- tx_data  input  16  response word; sampled when the frame starts
- rx_data  output  16  last complete word received
- rdy  output  1  high when rx_data holds a new valid word
- clr_rdy  input  1  consumer acknowledge; clears rdy
- frame_err  output  1  last frame ended with bit count != 16

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - all sync flops = 1
  - state = IDLE
  - shift register = 16'h0000
  - bit counter = 0
  - rx_data = 16'h0000
  - rdy = 0
  - frame_err = 0
- Synchronization and edge detection:
  - SS_n and SCLK each pass through SYNC_STAGES flops plus one history flop.
  - SCLK rise = sync & ~hist. SS_n fall = ~sync & hist. SS_n rise = sync & ~hist.
  - MOSI passes through SYNC_STAGES flops only, so the value used at a detected SCLK rise is the MOSI present at the pin rise. The monarch guarantees MOSI is stable from before the rise until at least 1 clk after it.
- State machine with 2 states:
  - IDLE:
    - On SS_n fall: load shift register <= tx_data, bit counter <= 0, clear rdy and frame_err, go to ACTIVE.
  - ACTIVE, on each SCLK rise:
    - shift register <= {shift[14:0], MOSI_sync}
    - bit counter += 1, saturating at 31
  - ACTIVE, on SS_n rise: go to IDLE.
    - If bit counter == 16: rx_data <= shift register and rdy <= 1 on that same clk.
    - Otherwise: frame_err <= 1; rx_data and rdy are unchanged.
- MISO = shift[15] while in ACTIVE, otherwise 1'bz.
  - Bit 15 of tx_data is present about 3 clks after the SS_n fall, well before the first SCLK rise.
  - Each subsequent MISO bit changes about 3 clks after an SCLK rise, before the monarch's next sample.
- Falling SCLK edges are ignored, including the leading fall at frame start.
- rdy and clr_rdy:
  - clr_rdy clears rdy the next clk.
  - If clr_rdy coincides with a successful frame end, set wins and rdy = 1.
- SCLK rise and SS_n rise in the same clk: the shift/count happens first, then the end-of-frame check uses the updated count.
- SS_n fall while already ACTIVE cannot occur. If SS_n toggles high then low again, the frame ends and a new one starts; each edge is processed in order.
- SCLK edges while in IDLE are ignored: no shift and no count.
- Latency: rx_data and rdy are valid SYNC_STAGES+1 clks after the pin-level SS_n rise.
- tx_data may change freely outside the SS_n fall-detect clk.
- Reset asserted mid-frame: return to IDLE immediately and tri-state MISO. The partial frame is discarded with no rdy and no frame_err.

Test Plan:
- Drive a back-to-back full monarch frame: tx_data=16'hA5C3, monarch writes 16'h1234 -> rx_data=16'h1234 and rdy=1 at SS_n rise+3 clks; monarch reads 16'hA5C3; frame_err=0.
- Run two consecutive frames, 16'hFFFF then 16'h0001 with tx 16'h8000 then 16'h7FFF. Assert clr_rdy between them -> rdy drops 1 clk after clr_rdy and rises again after frame 2; rx_data=16'h0001; monarch reads 16'h8000 then 16'h7FFF.
- Raise SS_n after 9 SCLK rises -> frame_err=1, rdy stays 0, rx_data retains the prior value. The next good frame clears frame_err and delivers its word.
- Hold clr_rdy high across the end of frame 16'hBEEF -> rdy=1 on the completion clk (set wins), 0 one clk later.
- Assert rst_n low after 8 bits of frame 16'h5555 -> MISO high-Z, rdy=0 and rx_data=0 immediately. A following full frame of 16'hC0DE is received correctly.
- Toggle SCLK 4 times with SS_n high -> no state change, MISO high-Z, bit counter stays 0.
